// File: rtl/axi_apb_bridge.sv
// axi_apb_bridge: AXI4-Lite responder that turns each AXI transaction into one APB transfer.
// Latency: grant N, psel N+1, penable N+2, B/RVALID the cycle after pready (minimum N+3).
// Backpressure: one transaction in flight; AXI READYs stay low until IDLE, responses held until B/RREADY.
// Optional: define AXI_APB_TIMEOUT_EN to end a stalled ACCESS phase as SLVERR after TIMEOUT_CYCLES.
module axi_apb_bridge #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    AXI_PCLK,
  input  logic                    AXI_PRESETn,
  input  logic [ADDR_WIDTH-1:0]   AXI4Lite_AWADDR,
  input  logic [2:0]              AXI4Lite_AWPROT,
  input  logic                    AXI4Lite_AWVALID,
  output logic                    AXI4Lite_AWREADY,
  input  logic [DATA_WIDTH-1:0]   AXI4Lite_WDATA,
  input  logic [DATA_WIDTH/8-1:0] AXI4Lite_WSTRB,
  input  logic                    AXI4Lite_WVALID,
  output logic                    AXI4Lite_WREADY,
  output logic [1:0]              AXI4Lite_BRESP,
  output logic                    AXI4Lite_BVALID,
  input  logic                    AXI4Lite_BREADY,
  input  logic [ADDR_WIDTH-1:0]   AXI4Lite_ARADDR,
  input  logic [2:0]              AXI4Lite_ARPROT,
  input  logic                    AXI4Lite_ARVALID,
  output logic                    AXI4Lite_ARREADY,
  output logic [DATA_WIDTH-1:0]   AXI4Lite_RDATA,
  output logic [1:0]              AXI4Lite_RRESP,
  output logic                    AXI4Lite_RVALID,
  input  logic                    AXI4Lite_RREADY,
  output logic [ADDR_WIDTH-1:0]   APB_paddr,
  output logic [DATA_WIDTH-1:0]   APB_pwdata,
  input  logic [DATA_WIDTH-1:0]   APB_prdata,
  output logic                    APB_psel,
  output logic                    APB_penable,
  output logic                    APB_pwrite,
  output logic [DATA_WIDTH/8-1:0] APB_pstb,
  input  logic                    APB_pready,
  input  logic                    APB_pslverr
);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {IDLE, SETUP, ACCESS, WRESP, RRESP} state_t;

  state_t     state, state_nxt;
  logic       last_wr;
  logic       elig_wr, elig_rd;
  logic       grant_wr, grant_rd;
  logic       timed_out;
  logic       xfer_done;
  logic [1:0] resp_nxt;
  logic       unused_prot;

  // Protection attributes carry no meaning on the APB side.
  assign unused_prot = ^{AXI4Lite_AWPROT, AXI4Lite_ARPROT};

  // A write needs both address and data present; a read needs only its address.
  assign elig_wr  = AXI4Lite_AWVALID && AXI4Lite_WVALID;
  assign elig_rd  = AXI4Lite_ARVALID;
  // Round-robin on contention; reset gating keeps READYs low while reset is held.
  assign grant_wr = AXI_PRESETn && (state == IDLE) && elig_wr && (!elig_rd || !last_wr);
  assign grant_rd = AXI_PRESETn && (state == IDLE) && elig_rd && !grant_wr;

`ifdef AXI_APB_TIMEOUT_EN
  localparam int CNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_WIDTH-1:0] access_cnt;

  // Count ACCESS cycles that passed without pready; restarts on every grant (SETUP entry).
  always_ff @(posedge AXI_PCLK or negedge AXI_PRESETn) begin
    if (!AXI_PRESETn)
      access_cnt <= '0;
    else if (grant_wr || grant_rd)
      access_cnt <= '0;
    else if (state == ACCESS && !APB_pready)
      access_cnt <= access_cnt + CNT_WIDTH'(1);
  end

  assign timed_out = (state == ACCESS) && !APB_pready &&
                     (access_cnt == CNT_WIDTH'(TIMEOUT_CYCLES - 1));
`else
  localparam int unused_timeout = TIMEOUT_CYCLES;
  assign timed_out = 1'b0;
`endif

  assign xfer_done = (state == ACCESS) && (APB_pready || timed_out);
  // A timed-out transfer (no pready) reports SLVERR just like a slave error.
  assign resp_nxt  = (!APB_pready || APB_pslverr) ? RESP_SLVERR : RESP_OKAY;

  // State register; reset abandons any transfer in progress.
  always_ff @(posedge AXI_PCLK or negedge AXI_PRESETn) begin
    if (!AXI_PRESETn) state <= IDLE;
    else              state <= state_nxt;
  end

  // Next-state logic: one APB transfer per grant, then wait for the AXI response handshake.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_wr || grant_rd) state_nxt = SETUP;
      SETUP:   state_nxt = ACCESS;
      ACCESS:  if (xfer_done) state_nxt = APB_pwrite ? WRESP : RRESP;
      WRESP:   if (AXI4Lite_BREADY) state_nxt = IDLE;
      RRESP:   if (AXI4Lite_RREADY) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Per-state handshake and APB phase outputs.
  always_comb begin
    AXI4Lite_AWREADY = 1'b0;
    AXI4Lite_WREADY  = 1'b0;
    AXI4Lite_ARREADY = 1'b0;
    AXI4Lite_BVALID  = 1'b0;
    AXI4Lite_RVALID  = 1'b0;
    APB_psel         = 1'b0;
    APB_penable      = 1'b0;
    case (state)
      IDLE: begin
        AXI4Lite_AWREADY = grant_wr;
        AXI4Lite_WREADY  = grant_wr;
        AXI4Lite_ARREADY = grant_rd;
      end
      SETUP:  APB_psel = 1'b1;
      ACCESS: begin
        APB_psel    = 1'b1;
        APB_penable = 1'b1;
      end
      WRESP:   AXI4Lite_BVALID = 1'b1;
      RRESP:   AXI4Lite_RVALID = 1'b1;
      default: ;
    endcase
  end

  // Capture the granted request; reads drive zero write data and strobes.
  always_ff @(posedge AXI_PCLK or negedge AXI_PRESETn) begin
    if (!AXI_PRESETn) begin
      APB_paddr  <= '0;
      APB_pwdata <= '0;
      APB_pstb   <= '0;
      APB_pwrite <= 1'b0;
      last_wr    <= 1'b1;
    end else if (grant_wr) begin
      APB_paddr  <= AXI4Lite_AWADDR;
      APB_pwdata <= AXI4Lite_WDATA;
      APB_pstb   <= AXI4Lite_WSTRB;
      APB_pwrite <= 1'b1;
      last_wr    <= 1'b1;
    end else if (grant_rd) begin
      APB_paddr  <= AXI4Lite_ARADDR;
      APB_pwdata <= '0;
      APB_pstb   <= '0;
      APB_pwrite <= 1'b0;
      last_wr    <= 1'b0;
    end
  end

  // Capture the response in the completing ACCESS cycle; held until the next completion.
  always_ff @(posedge AXI_PCLK or negedge AXI_PRESETn) begin
    if (!AXI_PRESETn) begin
      AXI4Lite_BRESP <= RESP_OKAY;
      AXI4Lite_RRESP <= RESP_OKAY;
      AXI4Lite_RDATA <= '0;
    end else if (xfer_done) begin
      if (APB_pwrite) begin
        AXI4Lite_BRESP <= resp_nxt;
      end else begin
        AXI4Lite_RRESP <= resp_nxt;
        AXI4Lite_RDATA <= APB_pready ? APB_prdata : '0;
      end
    end
  end

endmodule

// File: tb/tb_axi_apb_bridge.sv
// tb_axi_apb_bridge: table vectors, corner sequences and random traffic against a memory model.
// Latency: checks exact cycle of psel/penable/valid relative to the grant.
// Backpressure: exercises held responses, partial AW/W, contention and reset mid-transfer.
module tb_axi_apb_bridge;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] awaddr, wdata, araddr, rdata, paddr, pwdata, prdata;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb, pstb;
  logic [1:0]  bresp, rresp;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic        psel, penable, pwrite, pready, pslverr;

  always #5 clk = ~clk;

  axi_apb_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(8)) dut (
    .AXI_PCLK(clk), .AXI_PRESETn(rst_n),
    .AXI4Lite_AWADDR(awaddr), .AXI4Lite_AWPROT(awprot), .AXI4Lite_AWVALID(awvalid),
    .AXI4Lite_AWREADY(awready),
    .AXI4Lite_WDATA(wdata), .AXI4Lite_WSTRB(wstrb), .AXI4Lite_WVALID(wvalid),
    .AXI4Lite_WREADY(wready),
    .AXI4Lite_BRESP(bresp), .AXI4Lite_BVALID(bvalid), .AXI4Lite_BREADY(bready),
    .AXI4Lite_ARADDR(araddr), .AXI4Lite_ARPROT(arprot), .AXI4Lite_ARVALID(arvalid),
    .AXI4Lite_ARREADY(arready),
    .AXI4Lite_RDATA(rdata), .AXI4Lite_RRESP(rresp), .AXI4Lite_RVALID(rvalid),
    .AXI4Lite_RREADY(rready),
    .APB_paddr(paddr), .APB_pwdata(pwdata), .APB_prdata(prdata),
    .APB_psel(psel), .APB_penable(penable), .APB_pwrite(pwrite), .APB_pstb(pstb),
    .APB_pready(pready), .APB_pslverr(pslverr)
  );

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    int          waits;      // ACCESS cycles before pready
    logic        err;        // pslverr in the pready cycle
    int          rsp_delay;  // cycles B/RREADY held low
    logic [1:0]  exp_resp;
    logic [31:0] exp_rdata;
  } vec_t;

  int          nvec = 0;
  int          nerr = 0;
  logic [31:0] apb_mem [16];  // APB slave storage, indexed by paddr[5:2]
  logic [31:0] ref_mem [16];  // expected storage, updated from AXI-side requests
  vec_t        vecs [7];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic any_out();
    return |{awready, wready, arready, bvalid, rvalid, bresp, rresp, rdata,
             psel, penable, pwrite, paddr, pwdata, pstb};
  endfunction

  task automatic pulse_reset();
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic chk_apb(input vec_t v);
    chk("paddr", paddr, v.addr);
    chk("pwrite", pwrite, v.wr);
    chk("pwdata", pwdata, v.wr ? v.data : 32'h0);
    chk("pstb", pstb, v.wr ? v.strb : 4'h0);
  endtask

  // Entered just after a rising edge; returns just after the edge that ends the grant cycle.
  task automatic start_txn(input vec_t v, output logic ok);
    ok = 1'b0;
    if (v.wr) begin
      awaddr = v.addr; wdata = v.data; wstrb = v.strb;
      awprot = 3'($urandom); awvalid = 1'b1; wvalid = 1'b1;
    end else begin
      araddr = v.addr; arprot = 3'($urandom); arvalid = 1'b1;
    end
    for (int c = 0; c < 20 && !ok; c++) begin
      @(negedge clk);
      if (v.wr ? (awready && wready) : arready) ok = 1'b1;
      else begin @(posedge clk); #1; end
    end
    chk("grant", ok, 1'b1);
    if (ok) chk("grant_other", v.wr ? arready : (awready | wready), 1'b0);
    @(posedge clk); #1;
    if (v.wr) begin awvalid = 1'b0; wvalid = 1'b0; end
    else arvalid = 1'b0;
  endtask

  // Plays the APB slave from SETUP through the AXI response handshake.
  task automatic finish_txn(input vec_t v);
    @(negedge clk);
    chk("setup_phase", {psel, penable}, 2'b10);
    chk_apb(v);
    for (int j = 0; j <= v.waits; j++) begin
      @(posedge clk); #1;
      pready  = (j == v.waits);
      pslverr = (j == v.waits) ? v.err : 1'($urandom);
      prdata  = (j == v.waits) ? apb_mem[paddr[5:2]] : $urandom;
      @(negedge clk);
      chk("access_phase", {psel, penable}, 2'b11);
      chk_apb(v);
      chk("early_resp", {bvalid, rvalid}, 2'b00);
      if (j == v.waits && pwrite)
        for (int b = 0; b < 4; b++)
          if (pstb[b]) apb_mem[paddr[5:2]][8*b +: 8] = pwdata[8*b +: 8];
    end
    @(posedge clk); #1;
    pready = 1'b0; pslverr = 1'b0; prdata = $urandom;
    for (int d = 0; d <= v.rsp_delay; d++) begin
      @(negedge clk);
      if (d == v.rsp_delay) begin
        if (v.wr) bready = 1'b1; else rready = 1'b1;
      end
      #1;
      chk("resp_valid", v.wr ? {bvalid, rvalid} : {rvalid, bvalid}, 2'b10);
      chk("resp_apb_idle", {psel, penable}, 2'b00);
      chk("resp_code", v.wr ? bresp : rresp, v.exp_resp);
      if (!v.wr) chk("rdata", rdata, v.exp_rdata);
      chk("resp_no_ready", {awready, wready, arready}, 3'b000);
      @(posedge clk); #1;
      bready = 1'b0; rready = 1'b0; prdata = $urandom;
    end
    chk("resp_drop", {bvalid, rvalid}, 2'b00);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic ok;
    vec_t v, vr, vw;
    int   idx, seen;

    {awaddr, wdata, araddr, prdata, awprot, arprot, wstrb} = '0;
    {awvalid, wvalid, arvalid, bready, rready, pready, pslverr} = '0;
    for (int i = 0; i < 16; i++) apb_mem[i] = 32'h0;
    apb_mem[8] = 32'h1234_5678;

    vecs[0] = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 0, 1'b0, 0, 2'b00, 32'h0};
    vecs[1] = '{1'b0, 32'h0000_0020, 32'h0,        4'h0, 3, 1'b0, 1, 2'b00, 32'h1234_5678};
    vecs[2] = '{1'b1, 32'h0000_0014, 32'hA5A5_A5A5, 4'h3, 1, 1'b1, 0, 2'b10, 32'h0};
    vecs[3] = '{1'b0, 32'h0000_0010, 32'h0,        4'h0, 0, 1'b1, 2, 2'b10, 32'hDEAD_BEEF};
    vecs[4] = '{1'b0, 32'h0000_0014, 32'h0,        4'h0, 2, 1'b0, 0, 2'b00, 32'h0000_A5A5};
    vecs[5] = '{1'b1, 32'h1000_0008, 32'h1122_3344, 4'hA, 0, 1'b0, 0, 2'b00, 32'h0};
    vecs[6] = '{1'b0, 32'h1000_0008, 32'h0,        4'h0, 1, 1'b0, 0, 2'b00, 32'h1100_3300};

    // Reset with every request valid: all outputs must stay zero.
    #1 rst_n = 1'b0;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", any_out(), 1'b0);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Address without data, then data without address: no grant.
    awaddr = 32'h40; awvalid = 1'b1;
    repeat (3) begin @(negedge clk); chk("aw_only", {awready, wready, arready}, 3'b000); end
    awvalid = 1'b0; wvalid = 1'b1;
    repeat (3) begin @(negedge clk); chk("w_only", {awready, wready, arready}, 3'b000); end
    wvalid = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) begin
      start_txn(vecs[i], ok);
      if (ok) finish_txn(vecs[i]);
    end

    // Contention after reset: read first, then write, twice; read response held 4 cycles.
    pulse_reset();
    for (int r = 0; r < 2; r++) begin
      vr = '{1'b0, 32'h20, 32'h0, 4'h0, 0, 1'b0, 4, 2'b00, 32'h1234_5678};
      vw = '{1'b1, 32'h30 + 32'(r * 8), 32'hCAFE_0000 + 32'(r), 4'hF, 0, 1'b0, 0, 2'b00, 32'h0};
      araddr = vr.addr; awaddr = vw.addr; wdata = vw.data; wstrb = vw.strb;
      awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
      @(negedge clk);
      chk("rr_read_first", {arready, awready, wready}, 3'b100);
      @(posedge clk); #1;
      finish_txn(vr);
      @(negedge clk);
      chk("rr_write_next", {arready, awready, wready}, 3'b011);
      @(posedge clk); #1;
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
      finish_txn(vw);
    end

    // Reset during ACCESS: outputs clear at once, transfer abandoned, grant on first edge after.
    v = '{1'b1, 32'h3C, 32'h5555_AAAA, 4'hF, 0, 1'b0, 0, 2'b00, 32'h0};
    start_txn(v, ok);
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    chk("pre_reset_access", {psel, penable}, 2'b11);
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1; araddr = 32'h20;
    rst_n = 1'b0;
    #1;
    chk("reset_mid_access", any_out(), 1'b0);
    repeat (2) @(negedge clk);
    chk("reset_held", any_out(), 1'b0);
    awvalid = 1'b0; wvalid = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("first_grant", {arready, awready}, 2'b10);
    @(posedge clk); #1;
    arvalid = 1'b0;
    finish_txn('{1'b0, 32'h20, 32'h0, 4'h0, 0, 1'b0, 0, 2'b00, 32'h1234_5678});

    // Slave that never answers.
    v = '{1'b0, 32'h04, 32'h0, 4'h0, 0, 1'b0, 0, 2'b10, 32'h0};
    start_txn(v, ok);
    @(negedge clk);
`ifdef AXI_APB_TIMEOUT_EN
    for (int j = 0; j < 8; j++) begin
      @(posedge clk); #1;
      prdata = $urandom | 32'h1;
      @(negedge clk);
      chk("timeout_access", {psel, penable, rvalid}, 3'b110);
    end
    @(posedge clk); #1;
    @(negedge clk);
    chk("timeout_rvalid", {rvalid, psel, penable}, 3'b100);
    chk("timeout_rresp", rresp, 2'b10);
    chk("timeout_rdata", rdata, 32'h0);
    rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;
`else
    seen = 0;
    repeat (1000) begin
      @(negedge clk);
      if (bvalid || rvalid || !(psel && penable)) seen++;
    end
    chk("no_timeout", 32'(seen), 32'h0);
    pulse_reset();
`endif

    // Random traffic against a byte-merging memory model.
    for (int i = 0; i < 16; i++) ref_mem[i] = apb_mem[i];
    for (int n = 0; n < 40; n++) begin
      idx         = $urandom_range(0, 15);
      v.wr        = 1'($urandom_range(0, 1));
      v.addr      = ($urandom & 32'hFFFF_FFC0) | (32'(idx) << 2);
      v.data      = $urandom;
      v.strb      = 4'($urandom_range(0, 15));
      v.waits     = $urandom_range(0, 3);
      v.err       = 1'($urandom_range(0, 1));
      v.rsp_delay = $urandom_range(0, 2);
      v.exp_resp  = v.err ? 2'b10 : 2'b00;
      v.exp_rdata = ref_mem[idx];
      if (v.wr) begin
        for (int b = 0; b < 4; b++)
          if (v.strb[b]) ref_mem[idx][8*b +: 8] = v.data[8*b +: 8];
      end else begin
        v.data = 32'h0;
        v.strb = 4'h0;
      end
      start_txn(v, ok);
      if (ok) finish_txn(v);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/axi_apb_bridge.md
AXI_APB_BRIDGE -- requirements
Module: axi_apb_bridge

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, address width on both sides.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data width on both sides.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 255, ACCESS-phase cycle limit (used only under REQ-029).
REQ-004 SHALL have ports:
- AXI_PCLK  in  1  sole clock, rising edge.
- AXI_PRESETn  in  1  asynchronous active-low reset.
- AXI4Lite_AWADDR in ADDR_WIDTH; AWPROT in 3; AWVALID in 1; AWREADY out 1.
- AXI4Lite_WDATA in DATA_WIDTH; WSTRB in DATA_WIDTH/8; WVALID in 1; WREADY out 1.
- AXI4Lite_BRESP out 2; BVALID out 1; BREADY in 1.
- AXI4Lite_ARADDR in ADDR_WIDTH; ARPROT in 3; ARVALID in 1; ARREADY out 1.
- AXI4Lite_RDATA out DATA_WIDTH; RRESP out 2; RVALID out 1; RREADY in 1.
- APB_paddr out ADDR_WIDTH; APB_pwdata out DATA_WIDTH; APB_prdata in DATA_WIDTH.
- APB_psel out 1; APB_penable out 1; APB_pwrite out 1; APB_pstb out DATA_WIDTH/8.
- APB_pready in 1; APB_pslverr in 1.

Function
REQ-005 SHALL be an AXI4-Lite responder translating each AXI transaction into exactly one APB transfer; one transaction outstanding at a time.
REQ-006 SHALL implement states IDLE, SETUP, ACCESS, WRESP, RRESP.
REQ-007 In IDLE, write SHALL be eligible only when AWVALID and WVALID are both high; read eligible when ARVALID high.
REQ-008 Both eligible in IDLE: SHALL grant the type not granted last (round-robin); after reset, read wins first.
REQ-009 Write grant: AWREADY and WREADY SHALL pulse high together for exactly one cycle; address, data, strobes registered that cycle.
REQ-010 Read grant: ARREADY SHALL pulse high for one cycle; address registered.
REQ-011 Grant cycle SHALL transition IDLE->SETUP; READY outputs SHALL be low in every state except the granting IDLE cycle.
REQ-012 SETUP: psel=1, penable=0, paddr/pwrite/pwdata/pstb stable; next state ACCESS unconditionally.
REQ-013 ACCESS: psel=1, penable=1; remain until pready=1.
REQ-014 pstb SHALL equal registered WSTRB for writes and 0 for reads; pwdata SHALL be 0 for reads.
REQ-015 On ACCESS with pready=1: psel/penable drop next cycle; go to WRESP (write) or RRESP (read).
REQ-016 Read completion SHALL capture APB_prdata into RDATA in the pready cycle.
REQ-017 BRESP/RRESP SHALL be 2'b10 (SLVERR) if pslverr=1 in the pready cycle, else 2'b00.
REQ-018 WRESP: BVALID=1 held with BRESP stable until BREADY=1; then IDLE.
REQ-019 RRESP: RVALID=1 held with RDATA/RRESP stable until RREADY=1; then IDLE.
REQ-020 Minimum latency: grant at cycle N, psel at N+1, penable at N+2, pready at N+2 gives B/RVALID at N+3.
REQ-021 A new grant SHALL NOT occur in the cycle the response handshake completes; earliest next grant is the following IDLE cycle.
REQ-022 AWPROT/ARPROT SHALL be ignored.
REQ-023 AW without W (or W without AW) SHALL wait in IDLE, neither READY asserted.

Reset
REQ-024 AXI_PRESETn low SHALL asynchronously force IDLE, regardless of state.
REQ-025 During reset all outputs SHALL be 0: READYs, BVALID, RVALID, BRESP, RRESP, RDATA, psel, penable, pwrite, paddr, pwdata, pstb.
REQ-026 Round-robin history SHALL reset to "write last granted".
REQ-027 Reset mid-transfer SHALL abandon it with no response issued.
REQ-028 First grant possible on first rising edge after deassertion.

Configuration
REQ-029 With AXI_APB_TIMEOUT_EN defined: counter cleared on SETUP entry, incremented per ACCESS cycle; reaching TIMEOUT_CYCLES without pready SHALL end the transfer as SLVERR, RDATA=0, psel/penable dropped next cycle.
REQ-030 Without AXI_APB_TIMEOUT_EN: no counter logic; ACCESS waits indefinitely for pready.

Verification
REQ-031 Write AWADDR=0x10, WDATA=0xDEADBEEF, WSTRB=0xF, pready at first ACCESS -> APB write with same values, BVALID at N+3, BRESP=00.
REQ-032 Read ARADDR=0x20, prdata=0x12345678 after 3 wait cycles -> RVALID at N+6, RDATA=0x12345678, pstb=0.
REQ-033 AR and AW+W asserted together twice after reset -> read granted first, then write; RREADY held low 4 cycles keeps RVALID/RDATA stable.
REQ-034 pslverr=1 with pready on write -> BRESP=10; reset pulsed mid-ACCESS -> all outputs 0 immediately, no BVALID after.
REQ-035 AXI_APB_TIMEOUT_EN, TIMEOUT_CYCLES=8, pready never -> RVALID with RRESP=10, RDATA=0 after 8 ACCESS cycles; without macro, no response after 1000 cycles.
